forward_pipe: RTL and testbench

//   Multi-stage forward register slice for the valid/ready stream; companion to the backward skid buffer.

---
 rtl/forward_pipe.sv | 71 +++++++
 tb/tb_forward_pipe.sv | 124 ++++++++++++
 2 files changed

// File: rtl/forward_pipe.sv
// forward_pipe: multi-stage forward register slice for a valid/ready stream
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   flush          synchronous clear of all stages, blocks both handshakes
//   valid_f/ready_f/data_f  producer side
//   valid_b/ready_b/data_b  consumer side (registered valid and data)
//   count/full/empty        occupancy of the pipe
module forward_pipe #(
  parameter int L = 8,
  parameter int STAGES = 3,
  localparam int CW = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          valid_f,
  output logic          ready_f,
  input  logic [L-1:0]  data_f,
  output logic          valid_b,
  input  logic          ready_b,
  output logic [L-1:0]  data_b,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [STAGES-1:0] v;
  logic [L-1:0]      d  [STAGES];
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] sv;
  logic [L-1:0]      sd [STAGES];
  logic              in_x, out_x;
  // A stage may advance when the consumer takes a beat or any bubble sits at or after it,
  // written as a flat reduction so there is no combinational chain through go itself.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    assign go[g] = ready_b | ~&v[STAGES-1:g];
    if (g == 0) begin : g_src_in
      assign sv[g] = valid_f;
      assign sd[g] = data_f;
    end else begin : g_src_prev
      assign sv[g] = v[g-1];
      assign sd[g] = d[g-1];
    end
  end
  assign ready_f = go[0] & ~flush;
  assign valid_b = v[STAGES-1] & ~flush;
  assign data_b  = d[STAGES-1];
  assign in_x    = valid_f & ready_f;
  assign out_x   = valid_b & ready_b;
  assign full    = count == CW'(STAGES);
  assign empty   = count == '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (go[k]) begin
          v[k] <= sv[k];
          if (sv[k]) d[k] <= sd[k];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else if (flush) count <= '0;
    else count <= count + CW'(in_x) - CW'(out_x);
  end
endmodule

// File: tb/tb_forward_pipe.sv
// tb_forward_pipe: randomized and directed scoreboard bench for forward_pipe
module tb_forward_pipe;
  localparam int L = 8;
  localparam int STAGES = 3;
  localparam int CW = $clog2(STAGES + 1);
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic valid_f = 1'b0;
  logic ready_f;
  logic [L-1:0] data_f = '0;
  logic valid_b;
  logic ready_b = 1'b0;
  logic [L-1:0] data_b;
  logic [CW-1:0] count;
  logic full, empty;
  forward_pipe #(.L(L), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_f(valid_f), .ready_f(ready_f), .data_f(data_f),
    .valid_b(valid_b), .ready_b(ready_b), .data_b(data_b),
    .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  // Reference: an ideal FIFO of accepted beats, each carrying the number of edges since it
  // was accepted. The oldest beat is visible once it has aged STAGES-1 edges.
  typedef struct { logic [L-1:0] d; int age; } beat_t;
  beat_t q[$];
  int checks = 0;
  int errors = 0;
  bit acc = 1'b0;
  bit m_ov, m_rdy;
  function automatic bit e_valid();
    return !flush && q.size() > 0 && q[0].age >= STAGES - 1;
  endfunction
  function automatic bit e_ready();
    return !flush && (q.size() < STAGES || ready_b);
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      q.delete();
      acc = 1'b0;
    end else begin
      m_ov = e_valid();
      m_rdy = e_ready();
      acc = valid_f && m_rdy;
      if (m_ov && ready_b) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{d: data_f, age: 0});
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("valid_b", int'(valid_b), int'(e_valid()));
    chk("ready_f", int'(ready_f), int'(e_ready()));
    chk("count", int'(count), q.size());
    chk("full", int'(full), int'(q.size() == STAGES));
    chk("empty", int'(empty), int'(q.size() == 0));
    if (!rst) chk("data_b_rst", int'(data_b), 0);
    if (e_valid()) chk("data_b", int'(data_b), int'(q[0].d));
  end
  task automatic cyc(input bit vf, input logic [L-1:0] df, input bit rb, input bit fl);
    valid_f = vf;
    data_f = df;
    ready_b = rb;
    flush = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic push_beat(input logic [L-1:0] df, input bit rb);
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1, df, rb, 1'b0);
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL push_timeout: beat %0h not accepted within 40 cycles", df);
  endtask
  task automatic idle(input int n, input bit rb);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rb, 1'b0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2, 1'b1);
    for (int i = 1; i <= 16; i++) push_beat(L'(i), 1'b1);
    idle(5, 1'b1);
    push_beat(8'hA1, 1'b0);
    push_beat(8'hA2, 1'b0);
    push_beat(8'hA3, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hA4, 1'b0, 1'b0);
    push_beat(8'hA4, 1'b1);
    idle(5, 1'b1);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    idle(5, 1'b1);
    for (int i = 0; i < 3; i++) push_beat(8'h40 + L'(i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h50 + L'(i), 1'b1, 1'b0);
    idle(5, 1'b1);
    push_beat(8'hF1, 1'b0);
    push_beat(8'hF2, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(6, 1'b1);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom % 2), L'($urandom), ($urandom % 4) != 0, ($urandom % 32) == 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + L'(i), 1'b0, 1'b0);
    rst = 1'b0;
    idle(2, 1'b1);
    rst = 1'b1;
    idle(6, 1'b1);
    push_beat(8'h5A, 1'b1);
    idle(5, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
